toggle_pattern_gen: RTL and testbench
=====================================

Name: toggle_pattern_gen

Overview:
- Transmit-side stimulus source that serialises a loaded bit pattern onto a single line (`sout`) at a programmable bit period, with optional repeats.
- Produces the toggling/patterned signals that the team's assertion-based monitors sample at posedge clk.
- Sits between a bench/sequencer (load handshake) and any sampled-value checker or DUT input.

Parameters:
- WIDTH, 8, pattern length in bits (≥2).
- DIV_W, 8, width of the bit-period divider field.
- REP_W, 4, width of the repeat-count field.
- IDLE_LVL, 1'b0, level driven on sout when not transmitting.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  request to start a transmission.
- load_ready  out  1  high only in IDLE; transfer occurs when load_valid && load_ready at posedge.
- load_pattern  in  WIDTH  pattern, sent LSB first.
- load_div  in  DIV_W  each bit is held load_div+1 cycles.
- load_reps  in  REP_W  extra passes; total passes = load_reps+1.
- abort  in  1  stop the current transmission.
- sout  out  1  serial output.
- sout_valid  out  1  high while sout carries a pattern bit.
- bit_idx  out  $clog2(WIDTH)  index of the bit currently on sout (0 when idle).
- busy  out  1  high in SHIFT.
- done  out  1  one-cycle pulse after the final bit of the final pass.
- aborted  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; sout=IDLE_LVL; sout_valid=0; bit_idx=0; busy=0; done=0; aborted=0.
  - Internal counters are 0; load_ready=1 in the first cycle after reset.
- Reset mid-transmission: all of the above immediately (async). No done or aborted pulse is generated.
- FSM states: IDLE, SHIFT.
  - IDLE→SHIFT on load handshake. Capture pattern into a shadow register and into the shift register, div into a div register, and reps into rep_cnt.
  - SHIFT→IDLE on last bit expiry with rep_cnt==0, or on abort.
- Handshake and latency:
  - load_ready is combinational from state (IDLE only).
  - The cycle after the handshake: sout=pattern[0], sout_valid=1, busy=1, bit_idx=0.
  - load_valid during SHIFT is ignored. Inputs are not captured and there is no queueing.
- Bit timing:
  - A down-counter loads div on each new bit. The bit advances when the counter is 0, so each bit is held exactly div+1 cycles.
  - div=0 gives one bit per cycle.
- Pass end: when bit WIDTH-1 expires:
  - If rep_cnt≠0: decrement it, reload the shift register from the shadow register, and drive bit 0 in the next cycle. There is no gap and no idle cycle between passes.
  - Else: enter IDLE. In the next cycle sout=IDLE_LVL, sout_valid=0, busy=0, done=1 for exactly one cycle, and load_ready=1 in that same cycle.
- Back-to-back: a handshake in the cycle done is high is legal. The new first bit appears in the following cycle.
- Abort:
  - Sampled in SHIFT only; ignored in IDLE.
  - Next cycle: IDLE, sout=IDLE_LVL, sout_valid=0, aborted=1 for one cycle, no done.
  - If abort coincides with final-bit expiry, abort wins: aborted=1, done=0.
- Counter widths: no wrap. rep_cnt and the div counter saturate at 0 and are only reloaded on the events above.
- Total SHIFT cycles for one transmission = (reps+1)·WIDTH·(div+1).
- Outputs are registered, except load_ready.

Decomposition:
- Package toggle_pattern_pkg:
  - state enum typedef (IDLE, SHIFT).
  - Default WIDTH/DIV_W/REP_W localparams.
  - Function calculating expected transmission length, for bench scoreboards.
- One natural sub-module: bit_period_timer (loadable down-counter with zero flag), instantiated once for bit timing.
- Shift/repeat logic stays in the top module.

Test Plan:
- Reset then idle 5 cycles → sout=0, sout_valid=0, load_ready=1, done never asserted; reset asserted mid-SHIFT → outputs drop to reset values the same timestep.
- Load pattern=8'hA5, div=0, reps=0 → sout sequence 1,0,1,0,0,1,0,1 over 8 consecutive cycles starting 1 cycle after the handshake; done pulses on cycle 9; busy high for exactly 8 cycles.
- Load 8'h01, div=2, reps=1 → each bit held 3 cycles; 48 SHIFT cycles total; second pass starts with no gap; a single done pulse.
- Hold load_valid high with a different pattern during SHIFT → ignored, original pattern completes; handshake in the done cycle starts the new pattern in the next cycle.
- Assert abort on cycle 4 of an 8'hFF, div=1 transmission → next cycle sout=0, sout_valid=0, aborted=1, done=0; abort in IDLE → no effect.
- Abort coincident with final-bit expiry (8'h0F, div=0, abort on 8th bit cycle) → aborted=1, done=0; checker asserts that done and aborted are never high in the same cycle.

Source files
------------

// File: rtl/toggle_pattern_pkg.sv
// Shared types and defaults for the toggle pattern generator.
package toggle_pattern_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDivW  = 8;
  localparam int unsigned DefRepW  = 4;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  // Cycles spent in SHIFT for one uninterrupted transmission.
  function automatic int unsigned tx_cycles(input int unsigned width, input int unsigned div,
                                            input int unsigned reps);
    return (reps + 1) * width * (div + 1);
  endfunction

endpackage

// File: rtl/bit_period_timer.sv
// Loadable down-counter with zero flag; saturates at zero until reloaded.
module bit_period_timer #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  output logic             zero
);

  logic [DIV_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/toggle_pattern_gen.sv
// Serialises a loaded pattern LSB first onto sout at a programmable bit period,
// with optional repeat passes and abort.
module toggle_pattern_gen
  import toggle_pattern_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DIV_W    = DefDivW,
  parameter int unsigned REP_W    = DefRepW,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WIDTH-1:0]         load_pattern,
  input  logic [DIV_W-1:0]         load_div,
  input  logic [REP_W-1:0]         load_reps,
  input  logic                     abort,
  output logic                     sout,
  output logic                     sout_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  // Holds the bits still to be sent in this pass; the current bit lives in sout_q.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             sout_q, sout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             tmr_load;
  logic [DIV_W-1:0] tmr_val;
  logic             tmr_zero;

  bit_period_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    shift_d   = shift_q;
    div_d     = div_q;
    rep_cnt_d = rep_cnt_q;
    idx_d     = idx_q;
    sout_d    = sout_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = div_q;

    unique case (state_q)
      StIdle: begin
        if (load_valid) begin
          state_d   = StShift;
          shadow_d  = load_pattern;
          shift_d   = load_pattern[WIDTH-1:1];
          div_d     = load_div;
          rep_cnt_d = load_reps;
          idx_d     = '0;
          sout_d    = load_pattern[0];
          valid_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = load_div;
        end
      end
      StShift: begin
        // Abort takes priority over a coincident final-bit expiry.
        if (abort) begin
          state_d   = StIdle;
          sout_d    = IDLE_LVL;
          valid_d   = 1'b0;
          idx_d     = '0;
          aborted_d = 1'b1;
        end else if (tmr_zero) begin
          if (idx_q != LastIdx) begin
            shift_d  = shift_q >> 1;
            sout_d   = shift_q[0];
            idx_d    = idx_q + 1'b1;
            tmr_load = 1'b1;
          end else if (rep_cnt_q != '0) begin
            rep_cnt_d = rep_cnt_q - 1'b1;
            shift_d   = shadow_q[WIDTH-1:1];
            sout_d    = shadow_q[0];
            idx_d     = '0;
            tmr_load  = 1'b1;
          end else begin
            state_d = StIdle;
            sout_d  = IDLE_LVL;
            valid_d = 1'b0;
            idx_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      rep_cnt_q <= '0;
      idx_q     <= '0;
      sout_q    <= IDLE_LVL;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      rep_cnt_q <= rep_cnt_d;
      idx_q     <= idx_d;
      sout_q    <= sout_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign load_ready = (state_q == StIdle);
  assign busy       = (state_q == StShift);
  assign sout       = sout_q;
  assign sout_valid = valid_q;
  assign bit_idx    = idx_q;
  assign done       = done_q;
  assign aborted    = aborted_q;

endmodule

// File: tb/tb_toggle_pattern_gen.sv
// Bench for toggle_pattern_gen: directed table plus random transmissions scored
// against a queue-based expected waveform.
module tb_toggle_pattern_gen;
  import toggle_pattern_pkg::*;

  localparam int W  = 8;
  localparam int DW = 8;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [W-1:0]  load_pattern = '0;
  logic [DW-1:0] load_div = '0;
  logic [RW-1:0] load_reps = '0;
  logic          abort = 1'b0;
  logic          sout;
  logic          sout_valid;
  logic [2:0]    bit_idx;
  logic          busy;
  logic          done;
  logic          aborted;

  int n_vec = 0;
  int n_fail = 0;

  toggle_pattern_gen #(
    .WIDTH    (W),
    .DIV_W    (DW),
    .REP_W    (RW),
    .IDLE_LVL (1'b0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_pattern (load_pattern),
    .load_div     (load_div),
    .load_reps    (load_reps),
    .abort        (abort),
    .sout         (sout),
    .sout_valid   (sout_valid),
    .bit_idx      (bit_idx),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  pat;
    logic [DW-1:0] div;
    logic [RW-1:0] reps;
    int            abort_at;    // SHIFT cycle index on which abort is driven, -1 for none
    bit            hold_other;  // keep load_valid high with another pattern during SHIFT
    bit            b2b;         // next transmission handshakes in this one's done cycle
  } vec_t;

  function automatic logic [8:0] outs();
    return {load_ready, sout, sout_valid, busy, done, aborted, bit_idx};
  endfunction

  function automatic logic [8:0] exp_outs(input bit rdy, input bit s, input bit v, input bit b,
                                          input bit d, input bit a, input int idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {rdy, s, v, b, d, a, i3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      tick();
      chk("idle", 32'(outs()), 32'(exp_outs(1, 0, 0, 0, 0, 0, 0)));
    end
  endtask

  // Expected waveform: every bit of every pass, each repeated div+1 times.
  task automatic run_tx(input vec_t v, input string tag);
    bit eb[$];
    int ei[$];
    int n_cyc;
    bit took_abort;
    for (int p = 0; p <= int'(v.reps); p++)
      for (int i = 0; i < W; i++)
        for (int d = 0; d <= int'(v.div); d++) begin
          eb.push_back(v.pat[i]);
          ei.push_back(i);
        end
    n_cyc = eb.size();
    took_abort = 1'b0;
    if (v.abort_at >= 0 && v.abort_at < n_cyc) begin
      n_cyc = v.abort_at + 1;
      took_abort = 1'b1;
    end

    load_valid   = 1'b1;
    load_pattern = v.pat;
    load_div     = v.div;
    load_reps    = v.reps;
    chk({tag, " ready"}, 32'(load_ready), 32'd1);
    tick();
    load_valid   = v.hold_other;
    load_pattern = ~v.pat;
    load_div     = '0;
    load_reps    = '0;
    for (int c = 0; c < n_cyc; c++) begin
      chk($sformatf("%s shift c%0d", tag, c), 32'(outs()),
          32'(exp_outs(0, eb[c], 1, 1, 0, 0, ei[c])));
      abort = took_abort && (c == v.abort_at);
      tick();
    end
    abort      = 1'b0;
    load_valid = 1'b0;
    chk({tag, " end"}, 32'(outs()), 32'(exp_outs(1, 0, 0, 0, !took_abort, took_abort, 0)));
  endtask

  // Never both pulses in one cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      if (done && aborted) begin
        n_fail++;
        $display("FAIL done_and_aborted: got both high expected exclusive at %0t", $time);
      end
    end
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    tbl[0] = '{8'hA5, 8'd0, 4'd0, -1, 1'b0, 1'b0};
    tbl[1] = '{8'h01, 8'd2, 4'd1, -1, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 8'd1, 4'd0,  3, 1'b0, 1'b0};
    tbl[3] = '{8'h0F, 8'd0, 4'd0,  7, 1'b0, 1'b0};
    tbl[4] = '{8'h3C, 8'd0, 4'd0, -1, 1'b1, 1'b1};
    tbl[5] = '{8'hC3, 8'd1, 4'd0, -1, 1'b0, 1'b0};

    #1;
    chk("in_reset", 32'(outs()), 32'(exp_outs(1, 0, 0, 0, 0, 0, 0)));
    #11 rst_n = 1'b1;
    idle_cycles(5);

    for (int t = 0; t < 6; t++) begin
      run_tx(tbl[t], $sformatf("tbl%0d", t));
      if (!tbl[t].b2b) idle_cycles(1);
    end

    // Abort while idle has no effect.
    abort = 1'b1;
    idle_cycles(1);
    abort = 1'b0;
    idle_cycles(1);

    for (int r = 0; r < 20; r++) begin
      rv.pat        = W'($urandom);
      rv.div        = DW'($urandom_range(3));
      rv.reps       = RW'($urandom_range(2));
      rv.hold_other = 1'($urandom_range(1));
      rv.b2b        = 1'($urandom_range(1));
      rv.abort_at   = -1;
      if ($urandom_range(3) == 0)
        rv.abort_at = int'($urandom_range(tx_cycles(W, rv.div, rv.reps) - 1));
      run_tx(rv, $sformatf("rnd%0d", r));
      if (!rv.b2b) idle_cycles(1);
    end
    idle_cycles(1);

    // Async reset in the middle of a transmission.
    load_valid   = 1'b1;
    load_pattern = 8'hFF;
    load_div     = 8'd3;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'(outs()), 32'(exp_outs(1, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
